mem_sequencer: RTL and testbench

Initiator side of the 32×8 scratch memory. It accepts READ, WRITE, ADD and ADDC commands over a valid/ready port and drives the memory's level-sensitive read/write/address/data pins with glitch-safe sequencing. It returns one response per command. It sits between the adding-machine control path and the memory, and is the only block that drives the memory pins.

---
 rtl/mem_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_mem_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: initiator for the 32x8 scratch memory.
// Accepts READ / WRITE / ADD / ADDC commands over a valid/ready port, drives
// the memory's level-sensitive pins with a setup/strobe/hold write sequence,
// and returns one response pulse per command.
// Optional build macro: MEM_SEQUENCER_SAT_EN -- ADD/ADDC results that carry
// out are clamped to all-ones instead of wrapping.
module mem_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADDC  = 2'b11;
    localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD, S_RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        wait_cnt_reg, wait_cnt_next;
    logic [1:0]        op_reg, op_next;
    logic [ADDR_W-1:0] dst_reg, dst_next;
    logic [ADDR_W-1:0] src_a_reg, src_a_next;
    logic [ADDR_W-1:0] src_b_reg, src_b_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] op_a_reg, op_a_next;
    logic [DATA_W-1:0] op_b_reg, op_b_next;
    logic              carry_reg, carry_next;
    logic [DATA_W:0]   sum_wide;
    logic [DATA_W-1:0] result;

    // Every output is a register loaded from the value it must have in the
    // state being entered, so the pins change only at clock edges.
    logic              cmd_ready_reg, cmd_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_carry_reg, rsp_carry_next;
    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

    // State, captured command, operands, carry and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            op_reg        <= '0;
            dst_reg       <= '0;
            src_a_reg     <= '0;
            src_b_reg     <= '0;
            data_reg      <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            carry_reg     <= 1'b0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_carry_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            op_reg        <= op_next;
            dst_reg       <= dst_next;
            src_a_reg     <= src_a_next;
            src_b_reg     <= src_b_next;
            data_reg      <= data_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            carry_reg     <= carry_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_carry_reg <= rsp_carry_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    // Next state, command capture, operand sampling and carry update.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        op_next       = op_reg;
        dst_next      = dst_reg;
        src_a_next    = src_a_reg;
        src_b_next    = src_b_reg;
        data_next     = data_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        carry_next    = carry_reg;
        case (state_reg)
            S_IDLE: begin
                // Qualify with the registered ready so the first cycle out of
                // reset (ready still low) cannot accept.
                if (cmd_valid && cmd_ready_reg) begin
                    op_next    = cmd_op;
                    dst_next   = cmd_dst;
                    src_a_next = cmd_src_a;
                    src_b_next = cmd_src_b;
                    data_next  = cmd_data;
                    state_next = (cmd_op == OP_WRITE) ? S_WR_SETUP : S_RD_A;
                end
            end
            S_RD_A: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    op_a_next  = mem_rdata;
                    state_next = (op_reg == OP_READ) ? S_RESP : S_RD_B;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end
            S_RD_B: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    op_b_next  = mem_rdata;
                    state_next = S_WR_SETUP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end
            S_WR_SETUP:  state_next = S_WR_STROBE;
            S_WR_STROBE: state_next = S_WR_HOLD;
            S_WR_HOLD:   state_next = S_RESP;
            S_RESP:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase

        // Uses the operands as they will be once the second read completes;
        // ADDC folds in the carry left by the previous command.
        sum_wide = {1'b0, op_a_next} + {1'b0, op_b_next}
                 + {{DATA_W{1'b0}}, (op_reg == OP_ADDC) ? carry_reg : 1'b0};
`ifdef MEM_SEQUENCER_SAT_EN
        result = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
`else
        result = sum_wide[DATA_W-1:0];
`endif
        if (state_reg == S_RD_B && state_next == S_WR_SETUP) begin
            carry_next = sum_wide[DATA_W];
        end
    end

    // Output values for the state being entered; address/data hold otherwise.
    always_comb begin
        cmd_ready_next = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        rsp_carry_next = carry_next;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_next)
            S_IDLE: cmd_ready_next = 1'b1;
            S_RD_A: begin
                mem_read_next = 1'b1;
                mem_addr_next = src_a_next;
            end
            S_RD_B: begin
                mem_read_next = 1'b1;
                mem_addr_next = src_b_next;
            end
            S_WR_SETUP: begin
                mem_addr_next  = dst_next;
                mem_wdata_next = (op_next == OP_WRITE) ? data_next : result;
            end
            S_WR_STROBE: mem_write_next = 1'b1;
            S_WR_HOLD:   mem_write_next = 1'b0;
            S_RESP: begin
                rsp_valid_next = 1'b1;
                rsp_data_next  = (op_next == OP_READ) ? op_a_next : mem_wdata_reg;
            end
            default: cmd_ready_next = 1'b0;
        endcase
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_carry = rsp_carry_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer: table of directed commands against a 32x8
// combinational-read memory model, plus reset-during-write and back-to-back
// hand sequences. Honours MEM_SEQUENCER_SAT_EN for expected results.
module tb_mem_sequencer;

    localparam int RD_WAIT = 1;
`ifdef MEM_SEQUENCER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_ADDC  = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [4:0] cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid, rsp_carry, mem_read, mem_write;
    logic [7:0] rsp_data, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    logic [7:0] mem [32] = '{default: 8'h00};
    int total = 0;
    int bad = 0;
    int acc_cnt = 0, rsp_cnt = 0, wr_cnt = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] dst;
        logic [4:0] a;
        logic [4:0] b;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [17];

    mem_sequencer #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write while the strobe is high.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (rsp_valid) rsp_cnt++;
        if (mem_write) wr_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);

    function automatic logic [7:0] res(input logic [7:0] wrap, input logic c);
        return (SAT && c) ? 8'hFF : wrap;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        if (op == OP_READ)  return 1 + RD_WAIT;
        if (op == OP_WRITE) return 4;
        return 4 + 2 * RD_WAIT;
    endfunction

    // Issue one command (called just after a negedge) and check the whole
    // pin sequence up to and including the response.
    task automatic do_cmd(input int idx, input vec_t v);
        int n, k, lat;
        logic got, wr_type, exp_rd;
        lat = lat_of(v.op);
        wr_type = (v.op != OP_READ);
        cmd_op = v.op; cmd_dst = v.dst; cmd_src_a = v.a; cmd_src_b = v.b;
        cmd_data = v.data; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, n >= 50}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_dst = 5'h1F; cmd_src_a = 5'h1F; cmd_src_b = 5'h1F; cmd_data = 8'h00;
        k = 1;
        got = 1'b0;
        while (!got && k <= 20) begin
            exp_rd = (v.op == OP_READ) ? (k <= RD_WAIT) : (v.op != OP_WRITE && k <= 2 * RD_WAIT);
            chk("mem_read_seq", {31'd0, mem_read}, {31'd0, exp_rd});
            chk("mem_write_seq", {31'd0, mem_write}, {31'd0, wr_type && k == lat - 2});
            chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (wr_type && k >= lat - 3 && k <= lat - 1) begin
                chk("wr_addr", {27'd0, mem_addr}, {27'd0, v.dst});
                chk("wr_data", {24'd0, mem_wdata}, {24'd0, v.exp_data});
            end
            if (rsp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("rsp_latency", k, lat);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, v.exp_data});
        chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.exp_carry});
        $display("txn %0d op=%0d dst=%0d a=%0d b=%0d rsp_data=%h carry=%b lat=%0d",
                 idx, v.op, v.dst, v.a, v.b, rsp_data, rsp_carry, k);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        if (wr_type) chk("mem_content", {24'd0, mem[v.dst]}, {24'd0, v.exp_data});
    endtask

    initial begin
        int n, acc0, rsp0, wr0;
        vecs[0]  = '{OP_WRITE, 5'd3,  5'd0, 5'd0, 8'h5A, 8'h5A, 1'b0};
        vecs[1]  = '{OP_READ,  5'd0,  5'd3, 5'd0, 8'h00, 8'h5A, 1'b0};
        vecs[2]  = '{OP_WRITE, 5'd0,  5'd0, 5'd0, 8'hF0, 8'hF0, 1'b0};
        vecs[3]  = '{OP_WRITE, 5'd1,  5'd0, 5'd0, 8'h20, 8'h20, 1'b0};
        vecs[4]  = '{OP_ADD,   5'd2,  5'd0, 5'd1, 8'h00, res(8'h10, 1'b1), 1'b1};
        vecs[5]  = '{OP_ADDC,  5'd4,  5'd1, 5'd1, 8'h00, 8'h41, 1'b0};
        vecs[6]  = '{OP_READ,  5'd0,  5'd2, 5'd0, 8'h00, res(8'h10, 1'b1), 1'b0};
        vecs[7]  = '{OP_WRITE, 5'd0,  5'd0, 5'd0, 8'h80, 8'h80, 1'b0};
        vecs[8]  = '{OP_ADD,   5'd0,  5'd0, 5'd0, 8'h00, res(8'h00, 1'b1), 1'b1};
        vecs[9]  = '{OP_WRITE, 5'd5,  5'd0, 5'd0, 8'hFF, 8'hFF, 1'b1};
        vecs[10] = '{OP_ADDC,  5'd6,  5'd5, 5'd5, 8'h00, 8'hFF, 1'b1};
        vecs[11] = '{OP_WRITE, 5'd7,  5'd0, 5'd0, 8'h01, 8'h01, 1'b1};
        vecs[12] = '{OP_ADD,   5'd8,  5'd5, 5'd7, 8'h00, res(8'h00, 1'b1), 1'b1};
        vecs[13] = '{OP_ADD,   5'd9,  5'd7, 5'd7, 8'h00, 8'h02, 1'b0};
        vecs[14] = '{OP_ADDC,  5'd10, 5'd9, 5'd7, 8'h00, 8'h03, 1'b0};
        vecs[15] = '{OP_READ,  5'd0,  5'd4, 5'd0, 8'h00, 8'h41, 1'b0};
        vecs[16] = '{OP_ADD,   5'd11, 5'd5, 5'd5, 8'h00, res(8'hFE, 1'b1), 1'b1};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 17; i++) do_cmd(i, vecs[i]);

        // Reset while a WRITE is in its setup cycle (carry is 1 here).
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rsp0 = rsp_cnt; wr0 = wr_cnt;
        cmd_op = OP_WRITE; cmd_dst = 5'd12; cmd_data = 8'hAA; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_setup_addr", {27'd0, mem_addr}, 32'd12);
        chk("abort_setup_data", {24'd0, mem_wdata}, 32'hAA);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_write_low", {31'd0, mem_write}, 32'd0);
        chk("abort_ready_low", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_back", {31'd0, cmd_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("abort_no_strobe", wr_cnt - wr0, 0);
        chk("abort_no_rsp", rsp_cnt - rsp0, 0);
        chk("abort_mem_kept", {24'd0, mem[12]}, 32'd0);
        $display("txn abort write dst=12 mem=%h", mem[12]);
        do_cmd(17, '{OP_READ, 5'd0, 5'd12, 5'd0, 8'h00, 8'h00, 1'b0});

        // Back-to-back: valid held high for 30 cycles with a READ of word 3.
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc0 = acc_cnt; rsp0 = rsp_cnt;
        cmd_op = OP_READ; cmd_src_a = 5'd3; cmd_valid = 1'b1;
        repeat (30) @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b_accepts", acc_cnt - acc0, (30 + RD_WAIT + 1) / (RD_WAIT + 2));
        chk("b2b_rsp_per_accept", rsp_cnt - rsp0, acc_cnt - acc0);
        chk("b2b_last_data", {24'd0, rsp_data}, 32'h5A);
        $display("txn back-to-back accepts=%0d responses=%0d", acc_cnt - acc0, rsp_cnt - rsp0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
